readout_seq_v5: RTL

- Parametrised successor of the row readout sequencer.
- On a trigger it walks a programmable row window (start, step, count) and drives the pixel/column control strobes for each row.
- For each row it then scans NUM_GRP column-mux groups, in either CDS (reset+signal) or signal-only mode.
- It sits between the exposure controller (trigger/re_busy handshake) and the sensor pad drivers; it adds an aligned data-valid output and an abort input.

---
 rtl/readout_seq_v5.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/readout_seq_v5.sv
// Row readout sequencer: walks a programmable row window and, per row, drives the
// pixel/column strobes and scans the column-mux groups in CDS or signal-only mode.
module readout_seq_v5 #(
    parameter int AW  = 8,
    parameter int TW  = 12,
    parameter int GW  = 8,
    parameter int LAT = 8
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          trigger,
    input  logic          abort,
    input  logic          MODE,
    input  logic [AW-1:0] ROW_START,
    input  logic [AW-1:0] ROW_STEP,
    input  logic [AW-1:0] NUM_ROW,
    input  logic [GW-1:0] NUM_GRP,
    input  logic [TW-1:0] T_ADDR,
    input  logic [TW-1:0] T_RES,
    input  logic [TW-1:0] T_SAMP,
    input  logic [TW-1:0] T_XFER,
    input  logic [TW-1:0] T_READ,
    output logic          re_busy,
    output logic          frame_done,
    output logic [AW-1:0] ROWADD,
    output logic          COL_L_EN,
    output logic          COL_PRECH,
    output logic          PIXRES,
    output logic          SAMP_R,
    output logic          SAMP_S,
    output logic          MUX_START,
    output logic          READ_R,
    output logic          READ_S,
    output logic          dat_valid
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_RES,
        S_SAMPR,
        S_XFER,
        S_SAMPS,
        S_READR,
        S_READS,
        S_ROWEND,
        S_DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    state_t        first_read;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nxt;
    logic [GW-1:0] grp;
    logic [GW-1:0] grp_nxt;
    logic [AW-1:0] row;
    logic [AW-1:0] row_nxt;
    logic [AW-1:0] addr_nxt;
    logic          latch;
    logic          enter;
    logic          mux_nxt;

    logic          mode_q;
    logic [AW-1:0] row_step_q;
    logic [AW-1:0] num_row_q;
    logic [GW-1:0] num_grp_q;
    logic [TW-1:0] t_addr_q;
    logic [TW-1:0] t_res_q;
    logic [TW-1:0] t_samp_q;
    logic [TW-1:0] t_xfer_q;
    logic [TW-1:0] t_read_q;

    logic [LAT-1:0] vld_p;

    // Phase counters count down to zero; a programmed 0 behaves like 1.
    function automatic logic [TW-1:0] dur_m1(input logic [TW-1:0] d);
        return (d == '0) ? '0 : d - TW'(1);
    endfunction

    assign first_read = mode_q ? S_READS : S_READR;

    always_comb begin
        nxt      = state;
        grp_nxt  = grp;
        row_nxt  = row;
        addr_nxt = ROWADD;
        latch    = 1'b0;
        cnt_nxt  = (cnt == '0) ? '0 : cnt - TW'(1);
        if (state != S_IDLE && abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trigger && !abort) begin
                        latch    = 1'b1;
                        row_nxt  = '0;
                        addr_nxt = ROW_START;
                        nxt      = (NUM_ROW == '0) ? S_DONE : S_ADDR;
                    end
                end
                S_ADDR:  if (cnt == '0) nxt = S_RES;
                S_RES:   if (cnt == '0) nxt = mode_q ? S_XFER : S_SAMPR;
                S_SAMPR: if (cnt == '0) nxt = S_XFER;
                S_XFER:  if (cnt == '0) nxt = S_SAMPS;
                S_SAMPS: begin
                    if (cnt == '0) begin
                        grp_nxt = '0;
                        nxt     = (num_grp_q == '0) ? S_ROWEND : first_read;
                    end
                end
                S_READR: if (cnt == '0) nxt = S_READS;
                S_READS: begin
                    if (cnt == '0) begin
                        if (({1'b0, grp} + (GW+1)'(1)) >= {1'b0, num_grp_q}) begin
                            nxt = S_ROWEND;
                        end else begin
                            grp_nxt = grp + GW'(1);
                            nxt     = first_read;
                        end
                    end
                end
                S_ROWEND: begin
                    row_nxt  = row + AW'(1);
                    addr_nxt = ROWADD + row_step_q;
                    nxt      = (({1'b0, row} + (AW+1)'(1)) == {1'b0, num_row_q}) ? S_DONE : S_ADDR;
                end
                S_DONE:  if (cnt == '0) nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end

        // A new phase starts whenever the current one expires, even if the state repeats.
        enter = latch || (state != S_IDLE && !abort && cnt == '0 && nxt != S_IDLE);
        if (enter) begin
            case (nxt)
                S_ADDR:  cnt_nxt = dur_m1(latch ? T_ADDR : t_addr_q);
                S_RES:   cnt_nxt = dur_m1(t_res_q);
                S_SAMPR: cnt_nxt = dur_m1(t_samp_q);
                S_XFER:  cnt_nxt = dur_m1(t_xfer_q);
                S_SAMPS: cnt_nxt = dur_m1(t_samp_q);
                S_READR: cnt_nxt = dur_m1(t_read_q);
                S_READS: cnt_nxt = dur_m1(t_read_q);
                // An empty frame holds DONE for two cycles so it still reports two busy cycles.
                S_DONE:  cnt_nxt = latch ? TW'(1) : '0;
                default: cnt_nxt = '0;
            endcase
        end
        mux_nxt = enter && (nxt == S_READR || (nxt == S_READS && mode_q));
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            grp        <= '0;
            row        <= '0;
            ROWADD     <= '0;
            re_busy    <= 1'b0;
            frame_done <= 1'b0;
            COL_L_EN   <= 1'b0;
            COL_PRECH  <= 1'b0;
            PIXRES     <= 1'b0;
            SAMP_R     <= 1'b0;
            SAMP_S     <= 1'b0;
            MUX_START  <= 1'b0;
            READ_R     <= 1'b0;
            READ_S     <= 1'b0;
            vld_p      <= '0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            grp        <= grp_nxt;
            row        <= row_nxt;
            ROWADD     <= addr_nxt;
            re_busy    <= (nxt != S_IDLE);
            frame_done <= (nxt == S_DONE) && (cnt_nxt == '0);
            COL_L_EN   <= (nxt != S_IDLE) && (nxt != S_DONE);
            COL_PRECH  <= (nxt == S_ADDR);
            PIXRES     <= (nxt == S_RES);
            SAMP_R     <= (nxt == S_SAMPR);
            SAMP_S     <= (nxt == S_SAMPS);
            MUX_START  <= mux_nxt;
            READ_R     <= (nxt == S_READR);
            READ_S     <= (nxt == S_READS);
            vld_p      <= LAT'({vld_p, READ_R | READ_S});
        end
    end

    // Frame configuration, frozen at trigger acceptance.
    always_ff @(posedge CLK) begin
        if (latch) begin
            mode_q     <= MODE;
            row_step_q <= ROW_STEP;
            num_row_q  <= NUM_ROW;
            num_grp_q  <= NUM_GRP;
            t_addr_q   <= T_ADDR;
            t_res_q    <= T_RES;
            t_samp_q   <= T_SAMP;
            t_xfer_q   <= T_XFER;
            t_read_q   <= T_READ;
        end
    end

    assign dat_valid = vld_p[LAT-1];

endmodule
